p_test: RTL and testbench

- Micro-program branch-test (P-test) stage of the microprogrammed CPU control unit.
- Takes the 26-bit micro-instruction read from control store: 20-bit control field plus 6-bit next micro-address.
- Modifies the next-address field from the P-test bits, the current instruction opcode and the ALU status flags.
- Registers the result for the micro-sequencer, which uses it as the next control-store address.

---
 rtl/p_test_pkg.sv | 31 +++
 rtl/p_cond_mux.sv | 37 +++
 rtl/p_test.sv | 70 +++++++
 tb/tb_p_test.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/p_test_pkg.sv
// ============================================================================
// Module      : p_test_pkg
// Description : Shared field positions and condition codes for the P-test
//               branch stage of the micro-sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package p_test_pkg;

    localparam int AW      = 6;
    localparam int P3_BIT  = 21;
    localparam int P1_BIT  = 20;
    localparam int P2_BIT  = 19;
    localparam int COND_HI = 18;
    localparam int COND_LO = 16;

    typedef enum logic [2:0] {
        COND_CF     = 3'd0,
        COND_ZF     = 3'd1,
        COND_SF     = 3'd2,
        COND_OF     = 3'd3,
        COND_AF     = 3'd4,
        COND_NZ     = 3'd5,
        COND_NC     = 3'd6,
        COND_ALWAYS = 3'd7
    } cond_e;

endpackage

`default_nettype wire

// File: rtl/p_cond_mux.sv
// ============================================================================
// Module      : p_cond_mux
// Description : Combinational branch-condition selector (COND code + flags).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module p_cond_mux
    import p_test_pkg::*;
(
    input  logic [2:0] cond,
    input  logic       cf,
    input  logic       af,
    input  logic       zf,
    input  logic       sf,
    input  logic       of,
    output logic       cond_true
);

    always_comb begin
        cond_true = 1'b0;
        case (cond)
            COND_CF:     cond_true = cf;
            COND_ZF:     cond_true = zf;
            COND_SF:     cond_true = sf;
            COND_OF:     cond_true = of;
            COND_AF:     cond_true = af;
            COND_NZ:     cond_true = ~zf;
            COND_NC:     cond_true = ~cf;
            COND_ALWAYS: cond_true = 1'b1;
            default:     cond_true = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/p_test.sv
// ============================================================================
// Module      : p_test
// Description : P-test stage: ORs opcode / branch-condition bits into the
//               next-address field and registers the micro-instruction.
//               Define P_TEST_P3_EN to enable P3 addressing-mode dispatch.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module p_test #(
    parameter int UW = 26,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [UW-1:0] input_micro_op,
    input  logic [3:0]    in_op,
    input  logic          CF,
    input  logic          AF,
    input  logic          ZF,
    input  logic          SF,
    input  logic          OF,
    output logic [UW-1:0] output_micro_op
);

    import p_test_pkg::*;

    logic          w_cond_true;
    logic [UW-1:0] w_next_op;
    logic [UW-1:0] r_micro_op;

    p_cond_mux u_cond_mux (
        .cond      (input_micro_op[COND_HI:COND_LO]),
        .cf        (CF),
        .af        (AF),
        .zf        (ZF),
        .sf        (SF),
        .of        (OF),
        .cond_true (w_cond_true)
    );

    // Only OR operations touch the address, so P-bit order never matters.
    always_comb begin
        w_next_op = input_micro_op;
        if (input_micro_op[P1_BIT]) begin
            w_next_op[3:0] = w_next_op[3:0] | in_op;
        end
        if (input_micro_op[P2_BIT] && w_cond_true) begin
            w_next_op[0] = 1'b1;
        end
`ifdef P_TEST_P3_EN
        if (input_micro_op[P3_BIT]) begin
            w_next_op[AW-1:AW-2] = w_next_op[AW-1:AW-2] | in_op[1:0];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_micro_op <= '0;
        end else begin
            r_micro_op <= w_next_op;
        end
    end

    assign output_micro_op = r_micro_op;

endmodule

`default_nettype wire

// File: tb/tb_p_test.sv
// ============================================================================
// Module      : tb_p_test
// Description : Directed self-checking bench for the P-test stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_p_test;

    logic        clk;
    logic        rst;
    logic [25:0] input_micro_op;
    logic [3:0]  in_op;
    logic        CF, AF, ZF, SF, OF;
    logic [25:0] output_micro_op;

    int tests_run;
    int tests_failed;

    p_test #(.UW(26), .AW(6)) dut (
        .clk             (clk),
        .rst             (rst),
        .input_micro_op  (input_micro_op),
        .in_op           (in_op),
        .CF              (CF),
        .AF              (AF),
        .ZF              (ZF),
        .SF              (SF),
        .OF              (OF),
        .output_micro_op (output_micro_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // flags packed as {CF, AF, ZF, SF, OF}
    task automatic drive(input logic [25:0] uop, input logic [3:0] op, input logic [4:0] fl);
        input_micro_op = uop;
        in_op          = op;
        {CF, AF, ZF, SF, OF} = fl;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(26'h3FFFFFF, 4'hF, 5'b11111);
        for (int i = 0; i < 2; i++) begin
            tick();
            tests_run++;
            if (output_micro_op !== 26'h0000000) begin
                tests_failed++;
                $display("FAIL reset[%0d]: got %h expected %h", i, output_micro_op, 26'h0000000);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_pass_through();
        drive(26'h0020800, 4'h0, 5'b00000);
        tick();
        tests_run++;
        if (output_micro_op !== 26'h0020800) begin
            tests_failed++;
            $display("FAIL pass_through: got %h expected %h", output_micro_op, 26'h0020800);
        end
        // COND bits set but P2 clear: flags must have no effect
        drive(26'h0070000, 4'hF, 5'b11111);
        tick();
        tests_run++;
        if (output_micro_op !== 26'h0070000) begin
            tests_failed++;
            $display("FAIL cond_ignored: got %h expected %h", output_micro_op, 26'h0070000);
        end
    endtask

    task automatic test_p1_dispatch();
        drive(26'h0100001, 4'b0110, 5'b00000);
        tick();
        tests_run++;
        if (output_micro_op !== 26'h0100007) begin
            tests_failed++;
            $display("FAIL p1_dispatch: got %h expected %h", output_micro_op, 26'h0100007);
        end
        // upper address bits untouched by P1
        drive(26'h0100030, 4'hF, 5'b00000);
        tick();
        tests_run++;
        if (output_micro_op !== 26'h010003F) begin
            tests_failed++;
            $display("FAIL p1_upper: got %h expected %h", output_micro_op, 26'h010003F);
        end
    endtask

    task automatic test_p2_zf();
        drive(26'h0090010, 4'h0, 5'b00100);
        tick();
        tests_run++;
        if (output_micro_op !== 26'h0090011) begin
            tests_failed++;
            $display("FAIL p2_zf_true: got %h expected %h", output_micro_op, 26'h0090011);
        end
        drive(26'h0090010, 4'h0, 5'b00000);
        tick();
        tests_run++;
        if (output_micro_op !== 26'h0090010) begin
            tests_failed++;
            $display("FAIL p2_zf_false: got %h expected %h", output_micro_op, 26'h0090010);
        end
    endtask

    task automatic test_cond_codes();
        logic [25:0] vin  [13];
        logic [4:0]  vfl  [13];
        logic [25:0] vexp [13];
        vin[0]  = 26'h0080000; vfl[0]  = 5'b10000; vexp[0]  = 26'h0080001; // CF set
        vin[1]  = 26'h0080000; vfl[1]  = 5'b01111; vexp[1]  = 26'h0080000; // CF clear
        vin[2]  = 26'h00A0000; vfl[2]  = 5'b00010; vexp[2]  = 26'h00A0001; // SF set
        vin[3]  = 26'h00A0000; vfl[3]  = 5'b11101; vexp[3]  = 26'h00A0000; // SF clear
        vin[4]  = 26'h00B0000; vfl[4]  = 5'b00001; vexp[4]  = 26'h00B0001; // OF set
        vin[5]  = 26'h00C0000; vfl[5]  = 5'b01000; vexp[5]  = 26'h00C0001; // AF set
        vin[6]  = 26'h00C0000; vfl[6]  = 5'b10111; vexp[6]  = 26'h00C0000; // AF clear
        vin[7]  = 26'h00D0000; vfl[7]  = 5'b11011; vexp[7]  = 26'h00D0001; // !ZF, ZF=0
        vin[8]  = 26'h00D0000; vfl[8]  = 5'b00100; vexp[8]  = 26'h00D0000; // !ZF, ZF=1
        vin[9]  = 26'h00E0000; vfl[9]  = 5'b01111; vexp[9]  = 26'h00E0001; // !CF, CF=0
        vin[10] = 26'h00E0000; vfl[10] = 5'b10000; vexp[10] = 26'h00E0000; // !CF, CF=1
        vin[11] = 26'h00F0000; vfl[11] = 5'b00000; vexp[11] = 26'h00F0001; // always
        vin[12] = 26'h00B0000; vfl[12] = 5'b11110; vexp[12] = 26'h00B0000; // OF clear
        for (int i = 0; i < 13; i++) begin
            drive(vin[i], 4'h0, vfl[i]);
            tick();
            tests_run++;
            if (output_micro_op !== vexp[i]) begin
                tests_failed++;
                $display("FAIL cond_code[%0d]: got %h expected %h", i, output_micro_op, vexp[i]);
            end
        end
    endtask

    task automatic test_p1_p2();
        drive(26'h01F0020, 4'hA, 5'b00000);
        tick();
        tests_run++;
        if (output_micro_op !== 26'h01F002B) begin
            tests_failed++;
            $display("FAIL p1_p2_always: got %h expected %h", output_micro_op, 26'h01F002B);
        end
    endtask

    task automatic test_p3_bit();
        drive(26'h0200000, 4'h3, 5'b00000);
        tick();
        tests_run++;
`ifdef P_TEST_P3_EN
        if (output_micro_op !== 26'h0200030) begin
            tests_failed++;
            $display("FAIL p3_dispatch: got %h expected %h", output_micro_op, 26'h0200030);
        end
`else
        if (output_micro_op !== 26'h0200000) begin
            tests_failed++;
            $display("FAIL p3_passthrough: got %h expected %h", output_micro_op, 26'h0200000);
        end
`endif
    endtask

    task automatic test_reset_mid_stream();
        drive(26'h0100001, 4'hF, 5'b00000);
        tick();
        tests_run++;
        if (output_micro_op !== 26'h010000F) begin
            tests_failed++;
            $display("FAIL mid_pre_reset: got %h expected %h", output_micro_op, 26'h010000F);
        end
        rst = 1'b1;
        tick();
        tests_run++;
        if (output_micro_op !== 26'h0000000) begin
            tests_failed++;
            $display("FAIL mid_reset: got %h expected %h", output_micro_op, 26'h0000000);
        end
        rst = 1'b0;
        tick();
        tests_run++;
        if (output_micro_op !== 26'h010000F) begin
            tests_failed++;
            $display("FAIL mid_resume: got %h expected %h", output_micro_op, 26'h010000F);
        end
    endtask

    // Consecutive micro-ops must each appear exactly one edge after capture.
    task automatic test_back_to_back();
        drive(26'h0100000, 4'h5, 5'b00000);
        tick();
        drive(26'h0090010, 4'h0, 5'b00100);
        tests_run++;
        if (output_micro_op !== 26'h0100005) begin
            tests_failed++;
            $display("FAIL b2b_first: got %h expected %h", output_micro_op, 26'h0100005);
        end
        tick();
        tests_run++;
        if (output_micro_op !== 26'h0090011) begin
            tests_failed++;
            $display("FAIL b2b_second: got %h expected %h", output_micro_op, 26'h0090011);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        drive(26'h0, 4'h0, 5'b00000);
        #1;
        test_reset();
        test_pass_through();
        test_p1_dispatch();
        test_p2_zf();
        test_cond_codes();
        test_p1_p2();
        test_p3_bit();
        test_reset_mid_stream();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
